// File: rtl/sync2_pgen.sv
// Toggle synchroniser: two metastability flops plus a delayed copy.
// p is a one-cycle pulse for every toggle on d; flops are unreset.
module sync2_pgen (
  input  logic c,
  input  logic d,
  output logic q,
  output logic p
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // sync chain and edge-detect history
  always_ff @(posedge c) begin
    r_s1 <= d;
    r_s2 <= r_s1;
    r_s3 <= r_s2;
  end

  assign q = r_s2;
  assign p = r_s2 ^ r_s3;

endmodule

// File: rtl/cdc_pulse_arb.sv
// Round-robin scheduler sharing one toggle CDC channel among N
// requesters; regrants only after the returned ack toggle.
module cdc_pulse_arb #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           c,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   pend,
  output logic [N-1:0]   ovf,
  output logic           busy,
  output logic [IDW-1:0] id,
  output logic           t,
  input  logic           ack_t,
  output logic [N-1:0]   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
    S_WAIT
  } state_t;

  state_t         r_state;
  state_t         w_nstate;
  logic [N-1:0]   r_pend;
  logic [N-1:0]   r_ovf;
  logic [N-1:0]   r_done;
  logic [N-1:0]   w_pend_nxt;
  logic [N-1:0]   w_ovf_nxt;
  logic [N-1:0]   w_done_nxt;
  logic [N-1:0]   w_clr;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_id_nxt;
  logic [IDW-1:0] w_ptr_nxt;
  logic           r_t;
  logic           w_t_nxt;
  logic           w_ack;
  logic           w_ack_q_unused;

  // rotate so ptr is bit 0, take lowest set bit, rotate back
  function automatic logic [IDW-1:0] f_pick(
    input logic [N-1:0]   p,
    input logic [IDW-1:0] ptr
  );
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             j;
    int             s;
    dbl = {p, p} >> ptr;
    rot = dbl[N-1:0];
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) j = i;
    end
    s = int'(ptr) + j;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  // increment modulo N (N need not be a power of two)
  function automatic logic [IDW-1:0] f_inc(
    input logic [IDW-1:0] v
  );
    int s;
    s = int'(v) + 1;
    if (s >= N) s = 0;
    return IDW'(s);
  endfunction

  sync2_pgen u_ack (
    .c (c),
    .d (ack_t),
    .q (w_ack_q_unused),
    .p (w_ack)
  );

  // state register
  always_ff @(posedge c or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  // next state, grant, toggle and completion decode
  always_comb begin
    w_nstate   = r_state;
    w_t_nxt    = r_t;
    w_id_nxt   = r_id;
    w_ptr_nxt  = r_ptr;
    w_done_nxt = '0;
    w_clr      = '0;
    w_win      = f_pick(r_pend, r_ptr);
    unique case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_id_nxt     = w_win;
          w_ptr_nxt    = f_inc(w_win);
          w_clr[w_win] = 1'b1;
          w_nstate     = S_SETUP;
        end
      end
      S_SETUP: begin
        w_t_nxt  = ~r_t;
        w_nstate = S_SEND;
      end
      S_SEND: begin
        w_nstate = S_WAIT;
      end
      S_WAIT: begin
        if (w_ack) begin
          w_done_nxt[r_id] = 1'b1;
          w_nstate         = S_IDLE;
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
    w_pend_nxt = req | (r_pend & ~w_clr);
    w_ovf_nxt  = req & r_pend & ~w_clr;
  end

  // registered datapath and outputs
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= '0;
      r_done <= '0;
      r_id   <= '0;
      r_ptr  <= '0;
      r_t    <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
      r_done <= w_done_nxt;
      r_id   <= w_id_nxt;
      r_ptr  <= w_ptr_nxt;
      r_t    <= w_t_nxt;
    end
  end

  assign pend = r_pend;
  assign ovf  = r_ovf;
  assign done = r_done;
  assign id   = r_id;
  assign t    = r_t;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_cdc_pulse_arb.sv
// Bench for cdc_pulse_arb: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_cdc_pulse_arb;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic           c     = 1'b0;
  logic           rst   = 1'b1;
  logic           ack_t = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   pend;
  logic [N-1:0]   ovf;
  logic [N-1:0]   done;
  logic           busy;
  logic           t;
  logic [IDW-1:0] id;

  cdc_pulse_arb #(.N(N)) dut (
    .c     (c),
    .rst   (rst),
    .req   (req),
    .pend  (pend),
    .ovf   (ovf),
    .busy  (busy),
    .id    (id),
    .t     (t),
    .ack_t (ack_t),
    .done  (done)
  );

  always #5 c = ~c;

  int total = 0;
  int bad   = 0;

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // reference model: queue bits, a transfer phase, rr pointer
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_ovf   = '0;
  logic [N-1:0] m_done  = '0;
  int           m_phase = 0;
  int           m_ptr   = 0;
  int           m_id    = 0;
  logic         m_t     = 1'b0;
  logic [2:0]   m_h     = '0;
  bit           chk_en  = 0;

  // sampled history of ack_t, newest in bit 0
  always @(posedge c) m_h <= {m_h[1:0], ack_t};

  always @(posedge c or posedge rst) begin
    if (rst) begin
      m_pend  = '0;
      m_ovf   = '0;
      m_done  = '0;
      m_phase = 0;
      m_ptr   = 0;
      m_id    = 0;
      m_t     = 1'b0;
    end else begin
      logic [N-1:0] granted;
      int           w;
      bit           ack_seen;
      ack_seen = m_h[1] ^ m_h[2];
      granted  = '0;
      m_done   = '0;
      if (m_phase == 0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          if (w < 0 && m_pend[(m_ptr + k) % N])
            w = (m_ptr + k) % N;
        end
        if (w >= 0) begin
          m_id       = w;
          m_ptr      = (w + 1) % N;
          granted[w] = 1'b1;
          m_phase    = 1;
        end
      end else if (m_phase == 1) begin
        m_t     = ~m_t;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 3;
      end else if (ack_seen) begin
        m_done[m_id] = 1'b1;
        m_phase      = 0;
      end
      for (int i = 0; i < N; i++) begin
        m_ovf[i] = 1'b0;
        if (req[i]) begin
          if (m_pend[i] && !granted[i]) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (granted[i]) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge c) begin
    if (chk_en && !rst) begin
      check("pend", 32'(pend), 32'(m_pend));
      check("ovf",  32'(ovf),  32'(m_ovf));
      check("done", 32'(done), 32'(m_done));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("id",   32'(id),   32'(m_id));
      check("t",    32'(t),    32'(m_t));
    end
  end

  // destination responder and event counters
  int   cnt      = 0;
  int   dly      = 5;
  bit   auto_ack = 0;
  bit   rnd_dly  = 0;
  logic last_t   = 1'b0;
  int   toggles  = 0;
  int   done_cnt [N];
  int   ovf_cnt  [N];
  int   done_q   [$];

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin
      done_cnt[i] = 0;
      ovf_cnt[i]  = 0;
    end
    done_q.delete();
    toggles = 0;
  endtask

  task automatic tick();
    bit chg;
    @(negedge c);
    chg = (t !== last_t);
    if (chg) toggles++;
    for (int i = 0; i < N; i++) begin
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        done_q.push_back(i);
      end
      if (ovf[i] === 1'b1) ovf_cnt[i]++;
    end
    if (auto_ack) begin
      if (chg) begin
        cnt = rnd_dly ? int'($urandom_range(1, 8)) : dly;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ack_t = ~ack_t;
      end
    end
    last_t = t;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((busy || pend != '0) && n < lim) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(busy || pend != '0), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge c);
    rst = 1'b1;
    repeat (2) @(negedge c);
    rst    = 1'b0;
    cnt    = 0;
    last_t = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    clr_counts();
    repeat (3) @(negedge c);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id",   32'(id),   32'd0);
    check("rst_t",    32'(t),    32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst    = 1'b0;
    last_t = 1'b0;
    chk_en = 1;

    // single request, pinned timeline
    tick(); req = 4'b0100;
    tick(); req = '0;
    check("s_pend", 32'(pend), 32'b0100);
    check("s_busy0", 32'(busy), 32'd0);
    tick();
    check("s_id", 32'(id), 32'd2);
    check("s_busy1", 32'(busy), 32'd1);
    check("s_clr", 32'(pend), 32'd0);
    check("s_t_hold", 32'(t), 32'd0);
    tick();
    check("s_t", 32'(t), 32'd1);
    repeat (4) tick();
    ack_t = ~ack_t;
    tick(); check("s_done_k0", 32'(done), 32'd0);
    tick(); check("s_done_k1", 32'(done), 32'd0);
    tick();
    check("s_done_k2", 32'(done), 32'b0100);
    check("s_idle", 32'(busy), 32'd0);
    tick(); check("s_done_k3", 32'(done), 32'd0);

    // simultaneous requests from a fresh pointer
    do_reset();
    clr_counts();
    auto_ack = 1; dly = 5;
    tick(); req = 4'b1011;
    tick(); req = '0;
    drain(200);
    check("sim_n", 32'(done_q.size()), 32'd3);
    if (done_q.size() == 3) begin
      check("sim_0", 32'(done_q[0]), 32'd0);
      check("sim_1", 32'(done_q[1]), 32'd1);
      check("sim_2", 32'(done_q[2]), 32'd3);
    end
    check("sim_tog", 32'(toggles), 32'd3);

    // fairness under continuous pressure from 0 and 1
    clr_counts();
    begin
      int n = 0;
      req = 4'b0011;
      while (done_q.size() < 6 && n < 400) begin
        tick();
        n++;
      end
      req = '0;
      check("rr_count", 32'(done_q.size() >= 6), 32'd1);
      for (int k = 0; k < 6 && k < done_q.size(); k++)
        check("rr_order", 32'(done_q[k]), 32'(k % 2));
    end
    drain(200);

    // coalescing while requester 1 waits behind requester 0
    clr_counts();
    tick(); req = 4'b0001;
    tick(); req = 4'b0010;
    tick(); req = '0;
    tick(); req = 4'b0010;
    tick(); req = '0;
    drain(200);
    check("co_ovf1", 32'(ovf_cnt[1]), 32'd1);
    check("co_done1", 32'(done_cnt[1]), 32'd1);
    check("co_done0", 32'(done_cnt[0]), 32'd1);

    // stray acknowledge while idle
    clr_counts();
    auto_ack = 0;
    t0 = int'(t);
    ack_t = ~ack_t;
    repeat (6) tick();
    check("st_done", 32'(done_q.size()), 32'd0);
    check("st_t", 32'(t), 32'(t0));
    auto_ack = 1;
    tick(); req = 4'b1000;
    tick(); req = '0;
    drain(200);
    check("st_later", 32'(done_cnt[3]), 32'd1);

    // asynchronous reset in WAIT
    auto_ack = 0;
    tick(); req = 4'b0100;
    tick(); req = '0;
    repeat (5) tick();
    check("rw_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rw_pend", 32'(pend), 32'd0);
    check("rw_busy0", 32'(busy), 32'd0);
    check("rw_id", 32'(id), 32'd0);
    check("rw_t", 32'(t), 32'd0);
    ack_t = ~ack_t;
    repeat (3) @(negedge c);
    rst    = 1'b0;
    last_t = t;
    clr_counts();
    repeat (6) tick();
    check("rw_nodone", 32'(done_q.size()), 32'd0);

    // random traffic with stray acknowledges
    auto_ack = 1;
    rnd_dly  = 1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      for (int i = 0; i < N; i++)
        req[i] = ($urandom_range(0, 3) == 0);
      if (!busy && cnt == 0 && $urandom_range(0, 31) == 0)
        ack_t = ~ack_t;
    end
    tick(); req = '0;
    drain(500);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
